// File: rtl/gamma_encode_lut_stream.sv
// Purpose  : inverse-gamma (encode) pixel mapper through a double-buffered, host-programmable LUT.
// Latency  : 2 cycles for pixel data and the three sync signals, in every state.
// Backpress: none; the pixel stream is never stalled, and host writes/commits are never refused in RUN.
//
// Ports:
//   clk, rst                         pixel clock, asynchronous active-high reset
//   per_frame_vsync/href/clken       input syncs, per_img_Y linear input pixel
//   post_frame_vsync/href/clken      syncs delayed by 2 cycles
//   post_img_Y                       encoded pixel, 0 whenever post_frame_clken is 0
//   lut_wr_en/addr/data              host write port, always into the shadow bank
//   lut_commit                       request a shadow/active swap at the next frame start
//   lut_ready                        high once both banks hold the identity curve
//   swap_pending                     commit accepted, swap still waiting for a frame start
//   bank_sel                         index of the bank that pixels are read from
module gamma_encode_lut_stream #(
    parameter int   DATA_WIDTH = 8,
    parameter logic VSYNC_POL  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_Y,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic                  post_frame_clken,
    output logic [DATA_WIDTH-1:0] post_img_Y,
    input  logic                  lut_wr_en,
    input  logic [DATA_WIDTH-1:0] lut_wr_addr,
    input  logic [DATA_WIDTH-1:0] lut_wr_data,
    input  logic                  lut_commit,
    output logic                  lut_ready,
    output logic                  swap_pending,
    output logic                  bank_sel
);

    localparam int DEPTH = 1 << DATA_WIDTH;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] init_cnt;

    // Two LUT banks; bank_sel picks the one that feeds the pixel path.
    logic [DATA_WIDTH-1:0] bank0 [DEPTH];
    logic [DATA_WIDTH-1:0] bank1 [DEPTH];

    // Stage-1 registers: read address and syncs.
    logic                  vsync_d1, href_d1, clken_d1;
    logic [DATA_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  in_run;
    logic                  frame_start;

    assign in_run      = (state == ST_RUN);
    // vsync_d1 doubles as the delayed vsync for edge detection.
    assign frame_start = (per_frame_vsync == VSYNC_POL) && (vsync_d1 != VSYNC_POL);

    // ------------------------------------------------------------------
    // FSM: INIT sweeps every address once, then RUN forever.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (&init_cnt) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // LUT RAM. INIT loads identity into both banks; in RUN only the
    // shadow bank (the one not selected before any same-cycle swap) is
    // writable, so the curve in use can never change mid-frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            bank0[init_cnt] <= init_cnt;
            bank1[init_cnt] <= init_cnt;
        end else if (lut_wr_en) begin
            if (bank_sel) begin
                bank0[lut_wr_addr] <= lut_wr_data;
            end else begin
                bank1[lut_wr_addr] <= lut_wr_data;
            end
        end
    end

    assign rd_data = bank_sel ? bank1[rd_addr] : bank0[rd_addr];

    // ------------------------------------------------------------------
    // Pixel pipeline: stage 1 captures address + syncs, stage 2 captures
    // the active-bank data + syncs. Data is forced to 0 outside valid
    // pixels and while the LUT is still being initialised.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d1         <= 1'b0;
            href_d1          <= 1'b0;
            clken_d1         <= 1'b0;
            rd_addr          <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Y       <= '0;
        end else begin
            vsync_d1         <= per_frame_vsync;
            href_d1          <= per_frame_href;
            clken_d1         <= per_frame_clken;
            rd_addr          <= per_img_Y;
            post_frame_vsync <= vsync_d1;
            post_frame_href  <= href_d1;
            post_frame_clken <= clken_d1;
            post_img_Y       <= (in_run && clken_d1) ? rd_data : '0;
        end
    end

    // ------------------------------------------------------------------
    // Bank control. A commit arms the swap; the swap itself waits for a
    // frame start so a frame is always mapped by a single curve. A
    // commit that lands on the frame-start cycle swaps immediately.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_ready    <= 1'b0;
            swap_pending <= 1'b0;
            bank_sel     <= 1'b0;
        end else begin
            lut_ready <= in_run;
            if (in_run) begin
                if (frame_start && (swap_pending || lut_commit)) begin
                    bank_sel     <= ~bank_sel;
                    swap_pending <= 1'b0;
                end else if (lut_commit) begin
                    swap_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gamma_encode_lut_stream.sv
// Purpose  : self-checking bench for gamma_encode_lut_stream against a cycle-level behavioural model.
// Latency  : model predicts outputs 2 edges after inputs; compared #1 after every rising edge.
// Backpress: not applicable; stimulus is driven on falling edges.
module tb_gamma_encode_lut_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href  = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic [7:0] per_img_Y       = 8'h00;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0] post_img_Y;
    logic       lut_wr_en   = 1'b0;
    logic [7:0] lut_wr_addr = 8'h00;
    logic [7:0] lut_wr_data = 8'h00;
    logic       lut_commit  = 1'b0;
    logic       lut_ready, swap_pending, bank_sel;

    always #5 clk = ~clk;

    gamma_encode_lut_stream #(.DATA_WIDTH(8), .VSYNC_POL(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y),
        .lut_wr_en        (lut_wr_en),
        .lut_wr_addr      (lut_wr_addr),
        .lut_wr_data      (lut_wr_data),
        .lut_commit       (lut_commit),
        .lut_ready        (lut_ready),
        .swap_pending     (swap_pending),
        .bank_sel         (bank_sel)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Target encode curve: round(255 * (x/255)^(1/2.2)).
    logic [7:0] curve [256];

    // ------------------------------------------------------------------
    // Behavioural model: two curves, which one is live, a pending flag,
    // and a two-deep delay of the input syncs/pixels.
    // ------------------------------------------------------------------
    int         m_edges;          // rising edges since reset release
    logic [7:0] m_curve [2][256];
    logic       m_sel, m_pend, m_ready, m_vprev;
    logic       m1_v, m1_h, m1_c;
    logic [7:0] m1_y;
    logic       mo_v, mo_h, mo_c;
    logic [7:0] mo_y;

    task automatic m_reset();
        m_edges = 0;
        for (int i = 0; i < 256; i++) begin
            m_curve[0][i] = 8'(i);
            m_curve[1][i] = 8'(i);
        end
        m_sel = 0; m_pend = 0; m_ready = 0; m_vprev = 0;
        m1_v = 0; m1_h = 0; m1_c = 0; m1_y = 0;
        mo_v = 0; mo_h = 0; mo_c = 0; mo_y = 0;
    endtask

    always @(posedge clk) begin
        logic running, fstart;
        if (rst) begin
            m_reset();
        end else begin
            // Both banks hold identity after 256 init edges; ready one edge later.
            running = (m_edges >= 256);
            fstart  = per_frame_vsync && !m_vprev;
            mo_v = m1_v;
            mo_h = m1_h;
            mo_c = m1_c;
            mo_y = (running && m1_c) ? m_curve[m_sel][m1_y] : 8'h00;
            m_ready = running;
            if (running) begin
                if (lut_wr_en) m_curve[!m_sel][lut_wr_addr] = lut_wr_data;
                if (fstart && (m_pend || lut_commit)) begin
                    m_sel  = !m_sel;
                    m_pend = 0;
                end else if (lut_commit) begin
                    m_pend = 1;
                end
            end
            m1_v = per_frame_vsync;
            m1_h = per_frame_href;
            m1_c = per_frame_clken;
            m1_y = per_img_Y;
            m_vprev = per_frame_vsync;
            if (m_edges < 100000) m_edges++;
        end
        #1;
        chk("mdl_vsync", 32'(post_frame_vsync), 32'(mo_v));
        chk("mdl_href",  32'(post_frame_href),  32'(mo_h));
        chk("mdl_clken", 32'(post_frame_clken), 32'(mo_c));
        chk("mdl_pixel", 32'(post_img_Y),       32'(mo_y));
        chk("mdl_ready", 32'(lut_ready),        32'(m_ready));
        chk("mdl_pend",  32'(swap_pending),     32'(m_pend));
        chk("mdl_bank",  32'(bank_sel),         32'(m_sel));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: each step drives one cycle's inputs on a falling edge.
    // ------------------------------------------------------------------
    task automatic step(input logic v, input logic h, input logic c, input logic [7:0] y,
                        input logic we = 1'b0, input logic [7:0] wa = 8'h00,
                        input logic [7:0] wd = 8'h00, input logic cm = 1'b0);
        @(negedge clk);
        per_frame_vsync = v;
        per_frame_href  = h;
        per_frame_clken = c;
        per_img_Y       = y;
        lut_wr_en       = we;
        lut_wr_addr     = wa;
        lut_wr_data     = wd;
        lut_commit      = cm;
    endtask

    task automatic frame_start();
        repeat (3) step(1, 0, 0, 8'h00);
        repeat (2) step(0, 0, 0, 8'h00);
    endtask

    task automatic rand_line(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1'($urandom_range(0, 1)), 8'($urandom));
        step(0, 0, 0, 8'h00);
    endtask

    // One valid pixel, then check its mapped value 2 edges later.
    task automatic pix_check(input string name, input logic [7:0] y, input logic [7:0] exp);
        step(0, 1, 1, y);
        step(0, 1, 0, 8'($urandom));
        @(posedge clk);
        #1;
        chk(name, 32'(post_img_Y), 32'(exp));
    endtask

    // Reset released on a falling edge; the INIT window is hammered with
    // writes, commits, vsync edges and pixels that must all be ignored.
    task automatic release_and_init();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 250; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)));
        repeat (6) step(0, 0, 0, 8'h00);
        chk("ready_low_at_256", 32'(lut_ready), 32'd0);
        step(0, 0, 0, 8'h00);
        chk("ready_high_at_257", 32'(lut_ready), 32'd1);
        chk("bank_after_init", 32'(bank_sel), 32'd0);
        chk("pend_after_init", 32'(swap_pending), 32'd0);
    endtask

    initial begin
        for (int x = 0; x < 256; x++)
            curve[x] = 8'($rtoi($floor(255.0 * $pow(real'(x) / 255.0, 1.0 / 2.2) + 0.5)));
        // Pin the curve to its reference points.
        chk("curve_00", 32'(curve[0]),   32'h00);
        chk("curve_01", 32'(curve[1]),   32'h15);
        chk("curve_80", 32'(curve[128]), 32'hBA);
        chk("curve_ff", 32'(curve[255]), 32'hFF);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_pixel", 32'(post_img_Y), 32'h0);
        chk("rst_ready", 32'(lut_ready), 32'h0);
        chk("rst_bank",  32'(bank_sel), 32'h0);
        chk("rst_pend",  32'(swap_pending), 32'h0);

        release_and_init();

        // Identity after init, syncs delayed identically.
        pix_check("identity_5a", 8'h5A, 8'h5A);
        chk("sync_href_2cyc",  32'(post_frame_href), 32'd1);
        chk("sync_clken_2cyc", 32'(post_frame_clken), 32'd1);
        chk("sync_vsync_2cyc", 32'(post_frame_vsync), 32'd0);

        // Load full curve into the shadow bank, commit mid-frame.
        for (int x = 0; x < 256; x++) step(0, 0, 0, 8'h00, 1'b1, 8'(x), curve[x]);
        frame_start();
        rand_line(20);
        step(0, 1, 1, 8'($urandom), 1'b0, 8'h00, 8'h00, 1'b1);
        step(0, 1, 1, 8'($urandom));
        chk("pend_after_commit", 32'(swap_pending), 32'd1);
        pix_check("frame_stays_identity", 8'h80, 8'h80);
        rand_line(20);
        chk("bank_before_edge", 32'(bank_sel), 32'd0);
        frame_start();
        chk("bank_after_edge", 32'(bank_sel), 32'd1);
        chk("pend_after_edge", 32'(swap_pending), 32'd0);
        pix_check("curve_px_01", 8'h01, 8'h15);
        pix_check("curve_px_80", 8'h80, 8'hBA);
        pix_check("curve_px_ff", 8'hFF, 8'hFF);
        rand_line(30);

        // Shadow write without commit leaves the live curve untouched.
        step(0, 0, 0, 8'h00, 1'b1, 8'h80, 8'h00);
        for (int f = 0; f < 3; f++) begin
            frame_start();
            rand_line(10);
            pix_check("no_commit_80_holds", 8'h80, 8'hBA);
        end

        // Commit coinciding with the vsync rise swaps on that edge.
        step(1, 0, 0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        step(1, 0, 0, 8'h00);
        chk("edge_commit_bank", 32'(bank_sel), 32'd0);
        chk("edge_commit_pend", 32'(swap_pending), 32'd0);
        repeat (2) step(0, 0, 0, 8'h00);
        pix_check("edge_commit_80", 8'h80, 8'h00);
        pix_check("edge_commit_10", 8'h10, 8'h10);

        // Back-to-back pixels with clken toggling every cycle.
        for (int i = 0; i < 64; i++) step(0, 1, 1'(i % 2), 8'($urandom));
        step(0, 0, 0, 8'h00);

        // Random frames with random shadow writes and commits.
        for (int f = 0; f < 4; f++) begin
            frame_start();
            for (int i = 0; i < 80; i++)
                step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                     ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 19) == 0));
        end

        // Reset mid-frame while streaming.
        repeat (5) step(0, 1, 1, 8'h77);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_pixel", 32'(post_img_Y), 32'h0);
        chk("midrst_href",  32'(post_frame_href), 32'h0);
        chk("midrst_clken", 32'(post_frame_clken), 32'h0);
        chk("midrst_ready", 32'(lut_ready), 32'h0);
        chk("midrst_bank",  32'(bank_sel), 32'h0);
        repeat (2) @(negedge clk);
        release_and_init();
        pix_check("post_rst_identity_80", 8'h80, 8'h80);
        pix_check("post_rst_identity_01", 8'h01, 8'h01);
        repeat (4) step(0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
